pool_engine: RTL and testbench
==============================

# pool_engine

Parametrised pooling engine for the CNN pipeline; the successor to the fixed max-pool stage that sits between the convolution buffer and the OFM memory. On a `start` pulse it walks a channel-major input feature map (IFM) through a synchronous read port, reduces every POOL×POOL window by max or average, and writes the pooled output feature map (OFM) through a write port. The engine has configurable data width, map size, pool size and channel count, a runtime mode select, and base addresses latched at start.

## Interface
- `DATA_W`, default 8: unsigned pixel width.
- `ADDR_W`, default 10: address width of the read and write ports.
- `IN_DIM`, default 12: IFM side length. Must be a multiple of `POOL`.
- `POOL_LOG2`, default 1: log2 of the pool size, so `POOL = 1<<POOL_LOG2`. Stride equals `POOL`.
- `CH`, default 4: number of channels processed per run.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: pulse that launches a run; accepted only in IDLE.
- `mode` in 1: 0 = max, 1 = average; sampled on an accepted start.
- `in_base` in ADDR_W: IFM base address; sampled on an accepted start.
- `out_base` in ADDR_W: OFM base address; sampled on an accepted start.
- `rd_en` out 1: IFM read strobe.
- `rd_adr` out ADDR_W: IFM read address.
- `rd_data` in DATA_W: IFM data, valid exactly 1 cycle after the `rd_en` cycle.
- `wr_en` out 1: OFM write strobe.
- `wr_adr` out ADDR_W: OFM write address.
- `wr_data` out DATA_W: pooled value.
- `busy` out 1: high while a run is in progress.
- `done` out 1: 1-cycle completion pulse.

## Operation
- `OUT_DIM = IN_DIM >> POOL_LOG2`.
- IFM address for channel c, row r, column k: `in_base + c*IN_DIM² + r*IN_DIM + k`.
- OFM address for channel c, output row orow, output column ocol: `out_base + c*OUT_DIM² + orow*OUT_DIM + ocol`.
- All address arithmetic is modulo 2^ADDR_W and wraps silently.
- Iteration order: channel (outer), then output row, then output column. Inside each window, reads go in row-major order.
- FSM states:
  - IDLE: on `start`, latch `mode`, `in_base` and `out_base`, clear counters, go to READ.
  - READ: issue POOL² consecutive reads, one per cycle, then go to ACC.
  - ACC: absorb the last read datum, then go to WRITE.
  - WRITE: assert `wr_en` for 1 cycle. Go to READ for the next window, or to DONE after the last window of the last channel.
  - DONE: assert `done`, then go to IDLE.
- Accumulator, max mode: the first datum of a window loads the accumulator. Each later datum replaces it when the datum is strictly greater. `wr_data` is the accumulator value.
- Accumulator, average mode: the sum register is `DATA_W + 2*POOL_LOG2` bits wide, so it cannot overflow. The first datum loads the sum and later data add to it. `wr_data = sum >> (2*POOL_LOG2)`, truncating toward zero.
- A `start` while not in IDLE is ignored, and latched parameters do not change.

## Timing
- Reset values: all outputs are 0 (`rd_en`, `rd_adr`, `wr_en`, `wr_adr`, `wr_data`, `busy`, `done`). FSM = IDLE, counters = 0.
- `rst` asserted mid-run forces IDLE immediately. No further `rd_en` or `wr_en` is issued and no `done` is produced.
- All outputs are registered.
- `start` is sampled at edge 0, so the first `rd_en` is high in cycle 1.
- Each window costs POOL² + 2 cycles: the READ cycles, 1 ACC cycle and 1 WRITE cycle.
- `wr_en` for window w (0-based) is high in cycle `(w+1)*(POOL²+2)`.
- `done` is high in cycle `CH*OUT_DIM²*(POOL²+2) + 1`.
- `busy` is high from cycle 1 through the `done` cycle inclusive, and low in the following cycle.
- A new `start` is accepted in the cycle after `done`.
- `rd_en` and `wr_en` are never high in the same cycle.

## Test plan
Bench configuration: `IN_DIM=4`, `POOL_LOG2=1`, `CH=2`, `DATA_W=8`. The IFM model returns `mem[a] = a & 0xFF`.

- **Max mode.** `in_base=0`, `out_base=100`. Required: OFM[100..107] = 5, 7, 13, 15, 21, 23, 29, 31. `done` high in cycle 49 only. `busy` high in cycles 1..49.
- **Average mode, same map.** Required: OFM[100..107] = 2, 4, 10, 12, 18, 20, 26, 28. The first window {0,1,4,5} sums to 10, and 10>>2 = 2.
- **Saturation corner.** All IFM words = 255 in avg mode, then in max mode. Required: every output = 255 in both modes (sum 1020 fits in 10 bits).
- **Address wrap.** `in_base = 1020`. Required: read addresses wrap 1023 → 0. The first read sequence is 1020, 1021, 1024 mod 1024 = 0, 1.
- **Start while busy.** `start` pulses at cycles 10 and 30 with different `mode` and bases. Required: those pulses are ignored, the outputs match the first run, and only one `done` occurs.
- **Reset mid-run.** `rst` asserted in cycle 20. Required: all outputs 0 from assertion onward, with no write or `done`. After release, a fresh `start` reproduces the max-mode results exactly.

Source files
------------

// File: rtl/pool_engine.sv
// rtl/pool_engine.sv - POOLxPOOL max/average pooling engine over a channel-major feature map
module pool_engine #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int IN_DIM    = 12,
    parameter int POOL_LOG2 = 1,
    parameter int CH        = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] in_base,
    input  logic [ADDR_W-1:0] out_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_adr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_adr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);
    localparam int POOL    = 1 << POOL_LOG2;
    localparam int OUT_DIM = IN_DIM >> POOL_LOG2;
    localparam int KW      = 2 * POOL_LOG2 + 1;
    localparam int CW      = 16;
    localparam int SUM_W   = DATA_W + 2 * POOL_LOG2;

    typedef enum logic [2:0] {S_IDLE, S_READ, S_ACC, S_WRITE, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d;
    logic [ADDR_W-1:0]   in_base_q, in_base_d, out_base_q, out_base_d;
    logic [KW-1:0]       widx_q, widx_d;
    logic [CW-1:0]       ch_q, ch_d, oy_q, oy_d, ox_q, ox_d;
    logic [CW-1:0]       ch_n, oy_n, ox_n;
    logic                last_win;
    logic [SUM_W-1:0]    acc_q, acc_next, acc_shift;
    logic                rd_first_q, rd_first_d, dvalid_q, dfirst_q;
    logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   rd_adr_q, rd_adr_d, wr_adr_q, wr_adr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                busy_q, done_q;

    // Row-major offset inside the window: k = ky*POOL + kx.
    function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CW-1:0] c, input logic [CW-1:0] oy,
                                                  input logic [CW-1:0] ox, input logic [KW-1:0] k);
        logic [31:0] kx, ky;
        kx = 32'(k) & 32'(POOL - 1);
        ky = 32'(k) >> POOL_LOG2;
        return ADDR_W'(32'(base) + 32'(c) * 32'(IN_DIM * IN_DIM)
                       + (32'(oy) * 32'(POOL) + ky) * 32'(IN_DIM) + 32'(ox) * 32'(POOL) + kx);
    endfunction

    function automatic logic [ADDR_W-1:0] wr_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [CW-1:0] c, input logic [CW-1:0] oy,
                                                  input logic [CW-1:0] ox);
        return ADDR_W'(32'(base) + 32'(c) * 32'(OUT_DIM * OUT_DIM) + 32'(oy) * 32'(OUT_DIM) + 32'(ox));
    endfunction

    // Data returns one cycle after its read strobe; the first datum of a window reloads.
    always_comb begin
        acc_next = acc_q;
        if (dvalid_q) begin
            if (dfirst_q)
                acc_next = SUM_W'(rd_data);
            else if (mode_q)
                acc_next = acc_q + SUM_W'(rd_data);
            else if (rd_data > acc_q[DATA_W-1:0])
                acc_next = SUM_W'(rd_data);
        end
        acc_shift = acc_next >> (2 * POOL_LOG2);
    end

    always_comb begin
        ox_n = ox_q + CW'(1);
        oy_n = oy_q;
        ch_n = ch_q;
        if (ox_q == CW'(OUT_DIM - 1)) begin
            ox_n = '0;
            oy_n = oy_q + CW'(1);
            if (oy_q == CW'(OUT_DIM - 1)) begin
                oy_n = '0;
                ch_n = ch_q + CW'(1);
            end
        end
        last_win = (ch_q == CW'(CH - 1)) && (oy_q == CW'(OUT_DIM - 1)) && (ox_q == CW'(OUT_DIM - 1));
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        in_base_d  = in_base_q;
        out_base_d = out_base_q;
        widx_d     = widx_q;
        ch_d       = ch_q;
        oy_d       = oy_q;
        ox_d       = ox_q;
        rd_en_d    = 1'b0;
        rd_first_d = 1'b0;
        rd_adr_d   = rd_adr_q;
        wr_en_d    = 1'b0;
        wr_adr_d   = wr_adr_q;
        wr_data_d  = wr_data_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d    = S_READ;
                mode_d     = mode;
                in_base_d  = in_base;
                out_base_d = out_base;
                ch_d       = '0;
                oy_d       = '0;
                ox_d       = '0;
                rd_en_d    = 1'b1;
                rd_first_d = 1'b1;
                rd_adr_d   = rd_addr(in_base, '0, '0, '0, '0);
                widx_d     = KW'(1);
            end
            S_READ: begin
                if (widx_q == KW'(POOL * POOL)) begin
                    state_d = S_ACC;
                    widx_d  = '0;
                end else begin
                    rd_en_d  = 1'b1;
                    rd_adr_d = rd_addr(in_base_q, ch_q, oy_q, ox_q, widx_q);
                    widx_d   = widx_q + KW'(1);
                end
            end
            S_ACC: begin
                state_d   = S_WRITE;
                wr_en_d   = 1'b1;
                wr_adr_d  = wr_addr(out_base_q, ch_q, oy_q, ox_q);
                wr_data_d = mode_q ? acc_shift[DATA_W-1:0] : acc_next[DATA_W-1:0];
            end
            S_WRITE: begin
                if (last_win) begin
                    state_d = S_DONE;
                end else begin
                    state_d    = S_READ;
                    ch_d       = ch_n;
                    oy_d       = oy_n;
                    ox_d       = ox_n;
                    rd_en_d    = 1'b1;
                    rd_first_d = 1'b1;
                    rd_adr_d   = rd_addr(in_base_q, ch_n, oy_n, ox_n, '0);
                    widx_d     = KW'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            in_base_q  <= '0;
            out_base_q <= '0;
            widx_q     <= '0;
            ch_q       <= '0;
            oy_q       <= '0;
            ox_q       <= '0;
            acc_q      <= '0;
            rd_first_q <= 1'b0;
            dvalid_q   <= 1'b0;
            dfirst_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_adr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_adr_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            in_base_q  <= in_base_d;
            out_base_q <= out_base_d;
            widx_q     <= widx_d;
            ch_q       <= ch_d;
            oy_q       <= oy_d;
            ox_q       <= ox_d;
            acc_q      <= acc_next;
            rd_first_q <= rd_first_d;
            dvalid_q   <= rd_en_q;
            dfirst_q   <= rd_first_q;
            rd_en_q    <= rd_en_d;
            rd_adr_q   <= rd_adr_d;
            wr_en_q    <= wr_en_d;
            wr_adr_q   <= wr_adr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign rd_en   = rd_en_q;
    assign rd_adr  = rd_adr_q;
    assign wr_en   = wr_en_q;
    assign wr_adr  = wr_adr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
endmodule

// File: tb/tb_pool_engine.sv
// tb/tb_pool_engine.sv - scoreboard bench for pool_engine against a loop-level pooling model
module tb_pool_engine;
    localparam int DW = 8, AW = 10, IN = 4, PL = 1, NCH = 2;
    localparam int P = 1 << PL, OD = IN / P, WC = P * P + 2;

    logic          clk, rst, start, mode;
    logic [AW-1:0] in_base, out_base, rd_adr, wr_adr;
    logic          rd_en, wr_en, busy, done;
    logic [DW-1:0] rd_data, wr_data;

    pool_engine #(.DATA_W(DW), .ADDR_W(AW), .IN_DIM(IN), .POOL_LOG2(PL), .CH(NCH)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .in_base(in_base), .out_base(out_base),
        .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data), .wr_en(wr_en), .wr_adr(wr_adr),
        .wr_data(wr_data), .busy(busy), .done(done));

    typedef struct {logic [AW-1:0] adr; logic [DW-1:0] data; int cyc;} wr_t;

    logic [DW-1:0] mem [1024];
    logic [DW-1:0] ofm [1024];
    logic [AW-1:0] rq[$];
    wr_t           wq[$];
    int total = 0, bad = 0;
    int edge_cnt = 0, run_edge = 0, exp_done = 0;
    bit tracked = 0, done_seen = 0;
    int exp_max[8] = '{5, 7, 13, 15, 21, 23, 29, 31};
    int exp_avg[8] = '{2, 4, 10, 12, 18, 20, 26, 28};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;
    always @(posedge clk) rd_data <= rd_en ? mem[rd_adr] : DW'($urandom);

    function automatic void chk(string nm, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Reference: every window reduced directly from the IFM by its definition.
    task automatic push_model(input bit md, input logic [AW-1:0] ib, input logic [AW-1:0] ob);
        int w = 0;
        for (int c = 0; c < NCH; c++)
            for (int orow = 0; orow < OD; orow++)
                for (int ocol = 0; ocol < OD; ocol++) begin
                    int sum = 0, mx = 0;
                    wr_t e;
                    for (int i = 0; i < P; i++)
                        for (int j = 0; j < P; j++) begin
                            int a;
                            a = (int'(ib) + c * IN * IN + (orow * P + i) * IN + ocol * P + j) % 1024;
                            rq.push_back(AW'(a));
                            sum += int'(mem[a]);
                            if (int'(mem[a]) > mx) mx = int'(mem[a]);
                        end
                    e.adr  = AW'((int'(ob) + c * OD * OD + orow * OD + ocol) % 1024);
                    e.data = DW'(md ? sum / (P * P) : mx);
                    e.cyc  = (w + 1) * WC;
                    wq.push_back(e);
                    w++;
                end
        exp_done = w * WC + 1;
    endtask

    always @(negedge clk) begin
        int cyc;
        cyc = edge_cnt - run_edge + 1;
        if (rst) begin
            chk("reset_outputs", {rd_en, rd_adr, wr_en, wr_adr, wr_data, busy, done}, 0);
        end else begin
            if (rd_en || wr_en) chk("rd_wr_exclusive", rd_en & wr_en, 0);
            if (rd_en) begin
                if (rq.size() == 0) chk("unexpected_rd", rd_adr, -1);
                else chk("rd_adr", rd_adr, rq.pop_front());
            end
            if (wr_en) begin
                ofm[wr_adr] = wr_data;
                if (wq.size() == 0) chk("unexpected_wr", wr_adr, -1);
                else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_adr", wr_adr, e.adr);
                    chk("wr_data", wr_data, e.data);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end
            if (done) begin
                if (!tracked) chk("unexpected_done", 1, 0);
                else chk("done_cycle", cyc, exp_done);
                done_seen = 1;
            end
            if (tracked && cyc <= exp_done + 1) chk("busy", busy, (cyc <= exp_done) ? 1 : 0);
        end
    end

    task automatic launch(input bit md, input logic [AW-1:0] ib, input logic [AW-1:0] ob);
        @(negedge clk);
        push_model(md, ib, ob);
        done_seen = 0;
        start = 1; mode = md; in_base = ib; out_base = ob;
        @(posedge clk); #1;
        run_edge = edge_cnt;
        tracked = 1;
        start = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("wq_drained", wq.size(), 0);
        chk("rq_drained", rq.size(), 0);
    endtask

    task automatic check_ofm(input string nm, input bit avg, input bit sat);
        for (int i = 0; i < 8; i++)
            chk(nm, ofm[100 + i], sat ? 255 : (avg ? exp_avg[i] : exp_max[i]));
    endtask

    task automatic ramp_mem();
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    endtask

    initial begin
        rst = 1; start = 0; mode = 0; in_base = '0; out_base = '0;
        ramp_mem();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (2) @(posedge clk);

        launch(0, 10'd0, 10'd100); wait_done(); check_ofm("max_ofm", 0, 0);
        launch(1, 10'd0, 10'd100); wait_done(); check_ofm("avg_ofm", 1, 0);

        for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;
        launch(1, 10'd0, 10'd100); wait_done(); check_ofm("sat_avg", 1, 1);
        launch(0, 10'd0, 10'd100); wait_done(); check_ofm("sat_max", 0, 1);

        ramp_mem();
        launch(0, 10'd1020, 10'd0); wait_done();

        launch(0, 10'd0, 10'd100);
        repeat (9) @(posedge clk);
        #1 start = 1; mode = 1; in_base = 10'd500; out_base = 10'd200;
        @(posedge clk); #1 start = 0;
        repeat (19) @(posedge clk);
        #1 start = 1; mode = 1; in_base = 10'd300; out_base = 10'd600;
        @(posedge clk); #1 start = 0;
        wait_done(); check_ofm("busy_start_ofm", 0, 0);

        for (int i = 0; i < 1024; i++) ofm[i] = 8'h00;
        launch(0, 10'd0, 10'd100);
        repeat (19) @(posedge clk);
        #1 rst = 1;
        tracked = 0;
        rq.delete();
        wq.delete();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (6) @(posedge clk);
        launch(0, 10'd0, 10'd100); wait_done(); check_ofm("post_reset_ofm", 0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
            launch(1'($urandom), AW'($urandom), AW'($urandom));
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
